ps2_key_encoder: RTL and testbench
==================================

Name: ps2_key_encoder

Overview:
Converts the raw PS/2 keyboard serial line into the 11-bit ps2_key event word that the game tops decode: bit 10 toggles per event, bit 9 = pressed, bits 8:0 = {extended, scan code}. It is the producing end of the ps2_key interface, for builds without the HPS keyboard path (e.g. a direct PS/2 pin). It sits beside the top-level input decode and runs in the clk_25 domain.

Parameters:
FILTER_LEN, 8, clk_25 cycles a synchronised ps2_clk/ps2_data level must be stable before it is accepted.
TIMEOUT_CYC, 5000, clk_25 cycles without a falling ps2_clk edge mid-frame before the frame is abandoned (200 us at 25 MHz).

Ports:
clk_25     in   1   system clock
RESET_L    in   1   asynchronous active-low reset
ps2_clk    in   1   raw PS/2 clock, asynchronous to clk_25
ps2_data   in   1   raw PS/2 data, asynchronous to clk_25
ps2_key    out  11  event word: [10] toggle, [9] pressed, [8] extended, [7:0] code
frame_err  out  1   one-cycle pulse on parity, start, stop or timeout error
busy       out  1   high while a frame is in progress

Behaviour:
- Reset: ps2_key=0, frame_err=0, busy=0. All prefix flags are cleared, the skip counter is 0, and the filters preset to 1 (idle bus).
- Input path: a 2-flop synchroniser, then a FILTER_LEN stability filter per line. The filtered clock's 1->0 transition produces a one-cycle fall strobe. The data bit is taken as the filtered data value on that same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if data=0 go to DATA and clear bit count and timer. If data=1 on fall, pulse frame_err and stay in IDLE.
  - DATA: shift 8 bits LSB first into sr[7:0] (sr <= {d, sr[7:1]}). After the 8th bit go to PARITY.
  - PARITY: accept if (^sr ^ d)==1 (odd parity), else flag a pending error. Go to STOP.
  - STOP: d must be 1 and there must be no pending error; otherwise pulse frame_err. In both cases return to IDLE. A good frame presents byte_valid for one cycle with byte=sr.
- busy=1 in every state except IDLE.
- Timeout: an idle-gap timer runs whenever state is not IDLE and clears on each fall. When the timer reaches TIMEOUT_CYC-1, the FSM goes to IDLE, frame_err pulses, the partial byte is discarded, and the prefix flags are kept.
- Byte decoder (acts on byte_valid):
  - E0: set ext, no event.
  - F0: set brk, no event.
  - E1: set skip=7. Each of the next 7 valid bytes only decrements skip (Pause sequence swallowed). No event, and ext/brk are cleared.
  - FA, AA, EE, FE, 00, FF with no prefix set: ignored, no event. With a prefix set, treated as a code.
  - Any other byte: the cycle after byte_valid, ps2_key <= {~ps2_key[10], ~brk, ext, byte}. Then ext and brk clear.
- Latency: ps2_key updates 1 cycle after byte_valid, i.e. about 2+FILTER_LEN+2 clk_25 cycles after the stop-bit falling edge.
- Toggle: flips exactly once per event. Repeated make codes (typematic) each generate an event; there is no suppression.
- frame_err and byte_valid cannot coincide, because they are exclusive in STOP.
- Reset mid-frame: returns immediately to reset values, with no event emitted.
- Glitches shorter than FILTER_LEN cycles on either line have no effect.

Decomposition:
- Shared package ps2_pkg:
  - frame state enum
  - prefix constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1
  - ignore-list constants: FA, AA, EE, FE, 00, FF
  - PAUSE_TAIL=7
  - ps2_key bit-index localparams
- One sub-module, ps2_line_filter, instantiated twice (clock and data). It contains the synchroniser and stability counter, and outputs the filtered level plus the fall strobe.
- The FSM, timeout and decoder stay in ps2_key_encoder.

Test Plan:
- Frame 0x1C ('A') with odd parity 0, at a 12.5 kHz PS/2 clock -> ps2_key=11'b1_1_0_0001_1100, toggle 0->1, no frame_err.
- Sequence F0,1C -> one event ps2_key[9:0]=10'h01C with pressed=0. F0 alone produces no toggle.
- Sequence E0,75 then E0,F0,75 -> two events {pressed=1, ext=1, 0x75} then {pressed=0, ext=1, 0x75}. Toggle flips twice.
- Bad parity on 0x23 -> frame_err pulses once, ps2_key unchanged. The next good 0x23 produces an event.
- Clock held high after 4 data bits for 6000 cycles -> frame_err at cycle 5000, busy=0. The following good 0x29 frame decodes correctly.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> no event. The subsequent 0x05 yields an event. A 3-cycle ps2_clk glitch during IDLE produces no effect.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard types and constants.
// Frame states, prefix bytes and ps2_key bit positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR0  = 8'h00;
    localparam logic [7:0] PS2_OVR1  = 8'hFF;

    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam int KEY_TGL = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_ACK)  || (b == PS2_BAT)    ||
               (b == PS2_ECHO) || (b == PS2_RESEND) ||
               (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability filter for one raw PS/2 line.
// Emits the filtered level and a one-cycle 1->0 strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                // new level held long enough; strobe only on 1->0
                level <= sync;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver producing the 11-bit ps2_key event word.
// Frame FSM, mid-frame timeout and scan-code prefix decoder.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        clk_25,
    input  logic        RESET_L,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic          clk_lvl;
    logic          fall;
    logic          d;
    logic          d_fall;
    ps2_state_t    state;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic          perr;
    logic          byte_valid;
    logic          ext;
    logic          brk;
    logic [2:0]    skip;
    logic          timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk_25),
        .rst_n (RESET_L),
        .raw   (ps2_clk),
        .level (clk_lvl),
        .fall  (fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk_25),
        .rst_n (RESET_L),
        .raw   (ps2_data),
        .level (d),
        .fall  (d_fall)
    );

    assign busy    = (state != ST_IDLE);
    assign timeout = busy && !fall && (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            state      <= ST_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            timer      <= '0;
            perr       <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
            if (!busy || fall) timer <= '0;
            else               timer <= timer + 1'b1;
            if (timeout) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!d) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            perr    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        sr      <= {d, sr[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        perr  <= ~(^sr ^ d);
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (d && !perr) byte_valid <= 1'b1;
                        else            frame_err  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else if (byte_valid) begin
            if (skip != 3'd0) begin
                skip <= skip - 1'b1;
                ext  <= 1'b0;
                brk  <= 1'b0;
            end else if (sr == PS2_PAUSE) begin
                skip <= PAUSE_TAIL;
                ext  <= 1'b0;
                brk  <= 1'b0;
            end else if (sr == PS2_EXT) begin
                ext <= 1'b1;
            end else if (sr == PS2_BRK) begin
                brk <= 1'b1;
            end else if (!(is_ignored(sr) && !ext && !brk)) begin
                ps2_key <= {~ps2_key[KEY_TGL], ~brk, ext, sr};
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder.
// Drives PS/2 frames and checks event words and error pulses.
module tb_ps2_key_encoder;

    logic        clk_25 = 1'b0;
    logic        RESET_L;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int err_cnt = 0;

    localparam int FAST = 40;
    localparam int SLOW = 1000;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT_CYC(5000)) dut (
        .clk_25    (clk_25),
        .RESET_L   (RESET_L),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #20 clk_25 = ~clk_25;

    always @(posedge clk_25) if (frame_err) err_cnt++;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_25);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int half);
        ps2_data = b;
        cyc(half);
        ps2_clk = 1'b0;
        cyc(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad,
                        input int half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
        ps2_bit(~^b ^ bad, half);
        ps2_bit(1'b1, half);
        cyc(half + 30);
    endtask

    initial begin
        int n;
        int e0;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                8'hF0, 8'h14, 8'hF0, 8'h77};

        RESET_L  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        chk("rst_key", 16'(ps2_key), 16'h000);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_err", 16'(frame_err), 16'h0);
        RESET_L = 1'b1;
        cyc(20);

        send(8'h1C, 1'b0, SLOW);
        chk("make_1c", 16'(ps2_key), 16'h61C);
        chk("make_1c_err", 16'(err_cnt), 16'd0);

        send(8'hF0, 1'b0, FAST);
        chk("f0_alone", 16'(ps2_key), 16'h61C);
        send(8'h1C, 1'b0, FAST);
        chk("break_1c", 16'(ps2_key), 16'h01C);

        send(8'hE0, 1'b0, FAST);
        send(8'h75, 1'b0, FAST);
        chk("ext_make", 16'(ps2_key), 16'h775);
        send(8'hE0, 1'b0, FAST);
        send(8'hF0, 1'b0, FAST);
        send(8'h75, 1'b0, FAST);
        chk("ext_break", 16'(ps2_key), 16'h175);

        send(8'h23, 1'b1, FAST);
        chk("par_err_cnt", 16'(err_cnt), 16'd1);
        chk("par_err_key", 16'(ps2_key), 16'h175);
        send(8'h23, 1'b0, FAST);
        chk("after_par", 16'(ps2_key), 16'h623);

        send(8'hFA, 1'b0, FAST);
        chk("ignore_fa", 16'(ps2_key), 16'h623);

        // partial frame: start bit plus four data bits, then stall
        ps2_bit(1'b0, FAST);
        ps2_bit(1'b1, FAST);
        ps2_bit(1'b0, FAST);
        ps2_bit(1'b0, FAST);
        ps2_data = 1'b1;
        cyc(FAST);
        ps2_clk = 1'b0;
        e0 = err_cnt;
        n = 0;
        while (err_cnt == e0 && n < 7000) begin
            cyc(1);
            n++;
            if (n == FAST) ps2_clk = 1'b1;
            if (n == 100) chk("to_busy", 16'(busy), 16'h1);
        end
        chk("to_window", 16'(n >= 5000 && n <= 5030), 16'h1);
        cyc(2);
        chk("to_idle", 16'(busy), 16'h0);
        chk("to_err_cnt", 16'(err_cnt), 16'd2);
        cyc(1000);
        send(8'h29, 1'b0, FAST);
        chk("after_to", 16'(ps2_key), 16'h229);

        for (int i = 0; i < 8; i++) send(seq[i], 1'b0, FAST);
        chk("pause_swallow", 16'(ps2_key), 16'h229);
        send(8'h05, 1'b0, FAST);
        chk("after_pause", 16'(ps2_key), 16'h605);

        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(1);
        chk("glitch_busy", 16'(busy), 16'h0);
        cyc(40);
        chk("glitch_key", 16'(ps2_key), 16'h605);
        chk("glitch_err", 16'(err_cnt), 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
